ofm_write_controller: RTL

- Writer-side counterpart to the input/weight read-address controller of the conv engine.
- Accepts finished output-pixel results from the PE array over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Generates output-buffer write address, enable and byte write-enables in raster order: c fastest, then r, then output channel m.
- Signals done once a full output feature map (all channels) has been written.

---
 rtl/ofm_write_controller_if.sv | 24 ++
 rtl/ofm_write_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ofm_write_controller_if.sv
// Result stream (valid/ready) and output-buffer write port of the OFM write controller.
interface ofm_write_controller_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic                  res_valid;
  logic [DATA_W-1:0]     res_data;
  logic                  res_ready;
  logic                  out_hold;
  logic                  out_ena;
  logic [DATA_W/8-1:0]   out_wea;
  logic [ADDR_W-1:0]     out_addr;
  logic [DATA_W-1:0]     out_din;

  modport master (
    output res_valid, res_data, out_hold,
    input  res_ready, out_ena, out_wea, out_addr, out_din
  );

  modport slave (
    input  res_valid, res_data, out_hold,
    output res_ready, out_ena, out_wea, out_addr, out_din
  );
endinterface

// File: rtl/ofm_write_controller.sv
// Buffers PE results in a 2-entry FIFO and writes them to the output buffer in c/r/m raster order.
// Optional RELU_EN macro fuses a ReLU on the write data with no added latency.
module ofm_write_controller #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int OUT_SIZE    = 28,
  parameter int OUT_CHANNEL = 6,
  parameter int ROW_STRIDE  = 28,
  parameter int CH_STRIDE   = 784
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   start,
  ofm_write_controller_if.slave  bus,
  output logic                   busy,
  output logic                   done
);

  localparam int TOTAL = OUT_SIZE * OUT_SIZE * OUT_CHANNEL;
  localparam int ACC_W = $clog2(TOTAL + 1);
  localparam int C_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int M_W   = $clog2(OUT_CHANNEL + 1);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [2];
  logic [DATA_W-1:0]   mem_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [C_W-1:0]      c_q, c_d;
  logic [C_W-1:0]      r_q, r_d;
  logic [M_W-1:0]      m_q, m_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [ADDR_W-1:0]   ch_base_q, ch_base_d;
  logic                out_ena_q, out_ena_d;
  logic [BE_W-1:0]     out_wea_q, out_wea_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_din_q, out_din_d;

  logic                res_ready_c;
  logic                push, pop;
  logic                c_last, r_last, m_last;
  logic [DATA_W-1:0]   head;

  assign res_ready_c = (state_q == S_RUN) && (count_q != 2'd2) && (acc_q < ACC_W'(TOTAL));
  assign push        = bus.res_valid && res_ready_c;
  assign pop         = (state_q == S_RUN) && (count_q != 2'd0) && !bus.out_hold;
  assign head        = mem_q[rd_ptr_q];
  assign c_last      = (c_q == C_W'(OUT_SIZE - 1));
  assign r_last      = (r_q == C_W'(OUT_SIZE - 1));
  assign m_last      = (m_q == M_W'(OUT_CHANNEL - 1));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    acc_d      = acc_q;
    c_d        = c_q;
    r_d        = r_q;
    m_d        = m_q;
    row_base_d = row_base_q;
    ch_base_d  = ch_base_q;
    out_ena_d  = 1'b0;
    out_wea_d  = '0;
    out_addr_d = out_addr_q;
    out_din_d  = out_din_q;

    if (push) begin
      mem_d[wr_ptr_q] = bus.res_data;
      wr_ptr_d        = ~wr_ptr_q;
      acc_d           = acc_q + ACC_W'(1);
    end

    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      out_ena_d  = 1'b1;
      out_wea_d  = '1;
      out_addr_d = ch_base_q + row_base_q + ADDR_W'(c_q);
`ifdef RELU_EN
      out_din_d  = head[DATA_W-1] ? '0 : head;
`else
      out_din_d  = head;
`endif
      if (c_last) begin
        c_d = '0;
        if (r_last) begin
          r_d        = '0;
          row_base_d = '0;
          m_d        = m_q + M_W'(1);
          ch_base_d  = ch_base_q + ADDR_W'(CH_STRIDE);
          if (m_last) state_d = S_DONE;
        end else begin
          r_d        = r_q + C_W'(1);
          row_base_d = row_base_q + ADDR_W'(ROW_STRIDE);
        end
      end else begin
        c_d = c_q + C_W'(1);
      end
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // A new layer restarts the raster walk; start during RUN falls through untouched.
    if ((state_q != S_RUN) && start) begin
      state_d    = S_RUN;
      acc_d      = '0;
      c_d        = '0;
      r_d        = '0;
      m_d        = '0;
      row_base_d = '0;
      ch_base_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      acc_q      <= '0;
      c_q        <= '0;
      r_q        <= '0;
      m_q        <= '0;
      row_base_q <= '0;
      ch_base_q  <= '0;
      out_ena_q  <= 1'b0;
      out_wea_q  <= '0;
      out_addr_q <= '0;
      out_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      c_q        <= c_d;
      r_q        <= r_d;
      m_q        <= m_d;
      row_base_q <= row_base_d;
      ch_base_q  <= ch_base_d;
      out_ena_q  <= out_ena_d;
      out_wea_q  <= out_wea_d;
      out_addr_q <= out_addr_d;
      out_din_q  <= out_din_d;
    end
  end

  // NOTE: FIFO storage is not reset; a zero count already marks every entry invalid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign bus.res_ready = res_ready_c;
  assign bus.out_ena   = out_ena_q;
  assign bus.out_wea   = out_wea_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_din   = out_din_q;
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);

endmodule
